// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: bus stores feed a small TX FIFO that is sent as 8N1, LSB first.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   S_IDLE   | line high; pops the FIFO head into the shifter when data waits
//   S_START  | start bit (low) for BAUD_DIV cycles
//   S_DATA   | eight data bits, LSB first, BAUD_DIV cycles each
//   S_PARITY | even parity of the data byte (UART_TX_PARITY_EN only)
//   S_STOP   | stop bit (high) for BAUD_DIV cycles
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
  parameter int          BAUD_DIV   = 434,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Tx,
  output logic        Busy
);

  localparam int              PTR_W       = $clog2(FIFO_DEPTH);
  localparam logic [31:0]     STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [15:0]     BAUD_LAST   = 16'(BAUD_DIV - 1);
  localparam logic [PTR_W:0]  CNT_FULL    = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]  CNT_ONE     = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state, next_state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty, push_req, clr_req, push, pop, overflow;
  logic [15:0]      baud_cnt;
  logic             baud_done;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             tx_bit, busy_fsm;
  logic             unused_wdata;
`ifdef UART_TX_PARITY_EN
  logic             parity;
`endif

  assign unused_wdata = ^WriteData[31:8];

  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);
  assign push_req  = MemWrite && (DataAdr == BASE_ADDR);
  assign clr_req   = MemWrite && (DataAdr == STATUS_ADDR);
  assign push      = push_req && !full;
  assign pop       = (state == S_IDLE) && !empty;
  assign baud_done = (baud_cnt == BAUD_LAST);
  assign busy_fsm  = (state != S_IDLE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= WriteData[7:0];
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // full is the pre-pop value, so a store racing a pop still overflows
      if (push_req && full)
        overflow <= 1'b1;
      else if (clr_req)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state    <= next_state;
      baud_cnt <= (state == S_IDLE || baud_done) ? 16'd0 : baud_cnt + 16'd1;
      if (pop) begin
        shift   <= mem[rd_ptr];
        bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
        parity  <= ^mem[rd_ptr];
`endif
      end else if (state == S_DATA && baud_done) begin
        shift   <= {1'b0, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  always_comb begin
    next_state = state;
    tx_bit     = 1'b1;
    case (state)
      S_IDLE: begin
        if (!empty) next_state = S_START;
      end
      S_START: begin
        tx_bit = 1'b0;
        if (baud_done) next_state = S_DATA;
      end
      S_DATA: begin
        tx_bit = shift[0];
`ifdef UART_TX_PARITY_EN
        if (baud_done && bit_idx == 3'd7) next_state = S_PARITY;
`else
        if (baud_done && bit_idx == 3'd7) next_state = S_STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_bit = parity;
        if (baud_done) next_state = S_STOP;
      end
`endif
      S_STOP: begin
        if (baud_done) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign Tx       = tx_bit;
  assign Busy     = busy_fsm | !empty;
  assign ReadData = (DataAdr == STATUS_ADDR) ? {28'b0, overflow, empty, full, busy_fsm} : 32'h0;

endmodule
